// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Returns {remainder, quotient}; raises stallreq while an operation is pending.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               ge;

  always_comb begin
    abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    // The dividend is shifted through quo, so its MSB feeds the remainder LSB.
    // A set borrow bit out of the W+1-bit subtract means shifted rem < divisor.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    ge      = ~rem_sub[WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (opdata2 == '0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = abs1;
            dvs_d   = abs2;
            q_neg_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg_d = signed_div & opdata1[WIDTH-1];
          end
        end
      end
      S_DIVZERO: begin
        result_d = '0;
        state_d  = S_END;
      end
      S_ON: begin
        if (annul) begin
          state_d = S_IDLE;
        end else if (cnt_q != CW'(WIDTH)) begin
          quo_d = {quo_q[WIDTH-2:0], ge};
          rem_d = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          cnt_d = cnt_q + CW'(1);
        end else begin
          result_d = {(r_neg_q ? -rem_q : rem_q), (q_neg_q ? -quo_q : quo_q)};
          state_d  = S_END;
        end
      end
      S_END: begin
        if (annul || !start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_END);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign stallreq = start & ~ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes expected results, monitor pops on ready.
module tb_ex_div;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn, start, signed_div, annul;
  logic [W-1:0]  opdata1, opdata2;
  logic [2*W-1:0] result;
  logic          ready, stallreq;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .result(result), .ready(ready), .stallreq(stallreq)
  );

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] last_res = '0;
  logic        prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain 64-bit arithmetic; C-style truncating division.
  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    if (b == 0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare on each rising ready
  initial begin
    forever begin
      @(negedge clk);
      if (ready && !prev_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(cyc), 64'(e.cyc));
          last_res = e.res;
        end
      end
      prev_ready = ready;
    end
  end

  task automatic wait_ready();
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = ready;
      chk("stallreq", 64'(stallreq), 64'(!ready));
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 (t=%0t)", $time);
    end
    start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    opdata1 = a;
    opdata2 = b;
    signed_div = s;
    start = 1'b1;
    sb_q.push_back('{model(a, b, s), cyc + ((b == 0) ? 2 : W + 2)});
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    issue(a, b, s);
    @(posedge clk); #1;
    // Operands must be ignored once latched
    opdata1 = $urandom;
    opdata2 = $urandom;
    wait_ready();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int t0;
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #12;
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_result", result, 64'h0);
    chk("reset_stallreq", 64'(stallreq), 64'h0);
    #5 resetn = 1'b1;

    // Directed cases
    run_op(32'd7, 32'd2, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFFFFFE, 1'b1);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'd9, 32'd3, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0);
    run_op(32'h80000000, 32'd1, 1'b1);

    // Annul mid-operation, then immediate restart with start still high
    @(posedge clk); #1;
    opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_ready", 64'(ready), 64'h0);
    chk("annul_result", result, last_res);
    @(posedge clk); #1;
    annul = 1'b0;
    issue(32'hDEADBEEF, 32'd13, 1'b0);
    @(negedge clk);
    chk("annul_hold_result", result, last_res);
    wait_ready();

    // annul in IDLE blocks a same-cycle start
    @(posedge clk); #1;
    opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
    repeat (2) @(posedge clk);
    #1 annul = 1'b0;
    issue(32'd50, 32'd5, 1'b0);
    wait_ready();

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    issue(32'd12345, 32'd67, 1'b0);
    repeat (15) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_ready", 64'(ready), 64'h0);
    chk("async_reset_result", result, 64'h0);
    void'(sb_q.pop_back());
    last_res = '0;
    #2 start = 1'b0;
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 64'(ready), 64'h0);
    run_op(32'd100, 32'd9, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'h1;
        2: rb = $urandom_range(2, 50);
        3: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
